data_memory_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the single-port data memory (synchronous write, registered read address, word-indexed, 1-cycle read latency). Port 0 serves the CPU load/store path; port 1 serves a secondary master such as the debug/DMA loader. The block translates byte addresses to word indices, rejects misaligned or out-of-range accesses, and round-robins between the two ports. Only one memory access is in flight at any time.

---
 rtl/data_memory_arbiter_if.sv | 22 ++
 rtl/data_memory_arbiter.sv | 92 +++++++++
 tb/tb_data_memory_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_arbiter_if.sv
// data_memory_arbiter_if: two requester ports plus the single-port memory bus
interface data_memory_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req0, we0, ack0;
    logic                  req1, we1, ack1;
    logic [DATA_WIDTH-1:0] addr0, wdata0, addr1, wdata1;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err, busy;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_addr, mem_wdata, mem_rdata;

    modport master (
        output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
        input  ack0, ack1, rdata, err, busy, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
        output ack0, ack1, rdata, err, busy, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: round-robin two-port sequencer for a single-port data memory
module data_memory_arbiter #(
    parameter int                    MEMORY_DEPTH = 64,
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = 32'h1001_0000
) (
    input logic                  clk,
    input logic                  reset,
    data_memory_arbiter_if.slave bus
);
    localparam logic [DATA_WIDTH-1:0] LIMIT = DATA_WIDTH'(MEMORY_DEPTH * 4);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                state;
    logic                  prio, win, win_we;
    logic                  sel, we, legal;
    logic [DATA_WIDTH-1:0] addr, wdata, off;

    // pick the candidate port and decode its address; only used in IDLE
    always_comb begin
        sel   = (bus.req0 && bus.req1) ? prio : bus.req1;
        we    = sel ? bus.we1 : bus.we0;
        addr  = sel ? bus.addr1 : bus.addr0;
        wdata = sel ? bus.wdata1 : bus.wdata0;
        off   = addr - BASE_ADDR;
        legal = addr >= BASE_ADDR && off < LIMIT && addr[1:0] == 2'b00;
    end

    // sequencer: arbitrate, drive memory, collect data; acks are raised on entry to DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            prio          <= 1'b0;
            win           <= 1'b0;
            win_we        <= 1'b0;
            bus.ack0      <= 1'b0;
            bus.ack1      <= 1'b0;
            bus.err       <= 1'b0;
            bus.rdata     <= '0;
            bus.busy      <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.ack0 <= 1'b0;
            bus.ack1 <= 1'b0;
            bus.err  <= 1'b0;
            case (state)
                IDLE: if (bus.req0 || bus.req1) begin
                    win      <= sel;
                    win_we   <= we;
                    bus.busy <= 1'b1;
                    if (legal) begin
                        bus.mem_we    <= we;
                        bus.mem_addr  <= off >> 2;
                        bus.mem_wdata <= wdata;
                        state         <= ISSUE;
                    end else begin
                        bus.ack0  <= !sel;
                        bus.ack1  <= sel;
                        bus.err   <= 1'b1;
                        bus.rdata <= '0;
                        state     <= DONE;
                    end
                end
                ISSUE: begin
                    bus.mem_we <= 1'b0;
                    if (win_we) begin
                        bus.ack0  <= !win;
                        bus.ack1  <= win;
                        bus.rdata <= '0;
                        state     <= DONE;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    bus.ack0  <= !win;
                    bus.ack1  <= win;
                    bus.rdata <= bus.mem_rdata;
                    state     <= DONE;
                end
                default: begin
                    prio     <= !win;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb_data_memory_arbiter: table, hand-sequence and random checks against a behavioural model
module tb_data_memory_arbiter;
    localparam logic [31:0] BASE = 32'h1001_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    data_memory_arbiter_if #(.DATA_WIDTH(32)) bus ();

    data_memory_arbiter #(.MEMORY_DEPTH(64), .DATA_WIDTH(32), .BASE_ADDR(BASE)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // memory with synchronous write and registered read address
    logic [31:0] mem [64] = '{default: 32'h0};
    logic [5:0]  raddr = '0;
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr[5:0]] <= bus.mem_wdata;
        raddr <= bus.mem_addr[5:0];
    end
    assign bus.mem_rdata = mem[raddr];

    logic [31:0] ref_mem [64] = '{default: 32'h0};

    typedef struct {
        bit          p;
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        bit          e;
        int          lat;
        logic [31:0] rd;
        int          word;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic model(input logic [31:0] a, input bit w, input logic [31:0] d,
                         output bit e, output int lat, output logic [31:0] rd, output int word);
        longint off;
        off  = longint'(a) - longint'(BASE);
        e    = !(off >= 0 && off < 256 && off % 4 == 0);
        word = e ? 0 : int'(off / 4);
        lat  = e ? 1 : (w ? 2 : 3);
        rd   = '0;
        if (!e && w) ref_mem[word] = d;
        if (!e && !w) rd = ref_mem[word];
    endtask

    task automatic drive(input bit p, input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
        if (p) begin
            bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
        end else begin
            bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_ack0", bus.ack0, 0);
        chk("rst_ack1", bus.ack1, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
    endtask

    task automatic xfer(input bit p, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input bit e, input int lat, input logic [31:0] rd, input int word);
        int n;
        bit got, saw_we;
        @(negedge clk);
        drive(p, 1'b1, w, a, d);
        n = 0; got = 0; saw_we = 0;
        while (!got && n < 10) begin
            @(negedge clk);
            n++;
            if (bus.mem_we) saw_we = 1;
            if (n == 1 && !e) begin
                chk("issue_mem_we", bus.mem_we, w);
                chk("issue_mem_addr", bus.mem_addr, word);
                if (w) chk("issue_mem_wdata", bus.mem_wdata, d);
            end
            got = bus.ack0 || bus.ack1;
        end
        chk("ack_seen", got, 1);
        chk("ack_port", {bus.ack1, bus.ack0}, p ? 2'b10 : 2'b01);
        chk("latency", n, lat);
        chk("err", bus.err, e);
        if (!e || rd == 0) chk("rdata", bus.rdata, rd);
        if (e) chk("no_mem_we", saw_we, 0);
        drive(p, 1'b0, w, a, d);
        @(negedge clk);
        chk("ack_pulse", bus.ack0 | bus.ack1, 0);
        chk("idle_busy", bus.busy, 0);
    endtask

    initial begin
        bit          e;
        int          lat, word, n;
        bit          got;
        logic [31:0] rd, a;
        bit          p, w;

        tbl[0] = '{0, 1, 32'h1001_0008, 32'hDEAD_BEEF, 0, 2, 32'h0,         2};
        tbl[1] = '{0, 0, 32'h1001_0008, 32'h0,         0, 3, 32'hDEAD_BEEF, 2};
        tbl[2] = '{1, 0, 32'h1001_0002, 32'h0,         1, 1, 32'h0,         0};
        tbl[3] = '{1, 0, 32'h1001_0100, 32'h0,         1, 1, 32'h0,         0};
        tbl[4] = '{0, 0, 32'h1000_FFFC, 32'h0,         1, 1, 32'h0,         0};
        tbl[5] = '{0, 1, 32'h1001_00FC, 32'hA5A5_0001, 0, 2, 32'h0,         63};
        tbl[6] = '{0, 0, 32'h1001_00FC, 32'h0,         0, 3, 32'hA5A5_0001, 63};
        tbl[7] = '{1, 1, 32'h1001_0003, 32'h5555_AAAA, 1, 1, 32'h0,         0};
        tbl[8] = '{1, 1, 32'h1001_0010, 32'hCAFE_0004, 0, 2, 32'h0,         4};
        tbl[9] = '{0, 0, 32'h1001_0010, 32'h0,         0, 3, 32'hCAFE_0004, 4};

        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk_reset_vals();
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            model(tbl[i].a, tbl[i].w, tbl[i].d, e, lat, rd, word);
            xfer(tbl[i].p, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].e, tbl[i].lat, tbl[i].rd, tbl[i].word);
        end

        // contention right after reset: grants must alternate starting with port 0
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        drive(0, 1, 0, 32'h1001_0008, 0);
        drive(1, 1, 0, 32'h1001_00FC, 0);
        for (int k = 0; k < 4; k++) begin
            n = 0; got = 0;
            while (!got && n < 10) begin
                @(negedge clk);
                n++;
                got = bus.ack0 || bus.ack1;
            end
            chk("rr_ack_seen", got, 1);
            chk("rr_port", {bus.ack1, bus.ack0}, (k % 2) ? 2'b10 : 2'b01);
            chk("rr_latency", n, k == 0 ? 3 : 4);
            chk("rr_rdata", bus.rdata, (k % 2) ? ref_mem[63] : ref_mem[2]);
            if (k == 3) begin
                drive(0, 0, 0, 0, 0);
                drive(1, 0, 0, 0, 0);
            end
        end

        // abort a port 1 read in WAIT while the pointer names port 1
        model(32'h1001_0008, 0, 0, e, lat, rd, word);
        xfer(0, 0, 32'h1001_0008, 0, e, lat, rd, word);
        @(negedge clk);
        drive(1, 1, 0, 32'h1001_0028, 0);
        repeat (2) @(negedge clk);
        chk("wait_busy", bus.busy, 1);
        reset = 1'b1;
        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        chk_reset_vals();

        // write-before-read: port 0 wins after reset, port 1 then sees the new word
        reset = 1'b0;
        drive(0, 1, 1, 32'h1001_0014, 32'h1234_5678);
        drive(1, 1, 0, 32'h1001_0014, 0);
        n = 0; got = 0;
        while (!got && n < 10) begin
            @(negedge clk);
            n++;
            got = bus.ack0 || bus.ack1;
        end
        chk("wbr_first", {bus.ack1, bus.ack0}, 2'b01);
        chk("wbr_first_lat", n, 2);
        drive(0, 0, 0, 0, 0);
        ref_mem[5] = 32'h1234_5678;
        n = 0; got = 0;
        while (!got && n < 10) begin
            @(negedge clk);
            n++;
            got = bus.ack0 || bus.ack1;
        end
        chk("wbr_second", {bus.ack1, bus.ack0}, 2'b10);
        chk("wbr_second_lat", n, 4);
        chk("wbr_err", bus.err, 0);
        chk("wbr_rdata", bus.rdata, 32'h1234_5678);
        drive(1, 0, 0, 0, 0);

        // random single-port traffic against the behavioural model
        for (int i = 0; i < 60; i++) begin
            p = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0:       a = BASE + 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
                1:       a = BASE + 32'd256 + 32'($urandom_range(0, 1000) * 4);
                2:       a = BASE - 32'($urandom_range(1, 1000) * 4);
                default: a = BASE + 32'($urandom_range(0, 63) * 4);
            endcase
            model(a, w, $urandom, e, lat, rd, word);
            xfer(p, w, a, w ? ref_mem[word] : 32'h0, e, lat, rd, word);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
